// File: rtl/ham_scan_ctrl.sv
// Memory-master Hamming scanner: loads N_WORDS 16-bit operands, finds min/max pairwise
// distance and writes them to RES_ADDR/RES_ADDR+1. Define HAM_PAIR_ADDR_EN to also store the pair indices.
module ham_scan_ctrl #(
   parameter int N_WORDS   = 32,
   parameter int BASE_ADDR = 0,
   parameter int RES_ADDR  = 64,
   parameter int AW        = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   input  logic [7:0]    mem_rd_data,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wr_data
);

`ifdef HAM_PAIR_ADDR_EN
   localparam int WR_N = 6;
`else
   localparam int WR_N = 2;
`endif
   localparam int LOAD_LAST = 2 * N_WORDS;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_WRITE, S_DONE} state_t;
   state_t r_state, w_next;

   logic [15:0] r_ops [N_WORDS];
   logic [6:0]  r_cnt;
   logic [2:0]  r_wcnt;
   logic [4:0]  r_j, r_k, r_min, r_max;
   logic        r_req_q, r_done;
`ifdef HAM_PAIR_ADDR_EN
   logic [4:0]  r_min_j, r_min_k, r_max_j, r_max_k;
`endif

   logic        w_trigger, w_load_last, w_last_pair;
   logic [5:0]  w_cap_idx;
   logic [4:0]  w_dist;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int b = 0; b < 16; b++) c = c + {4'd0, v[b]};
      return c;
   endfunction

   assign w_trigger   = (r_state == S_IDLE) && !req && r_req_q;
   assign w_load_last = (r_cnt == 7'(LOAD_LAST));
   assign w_last_pair = (r_j == 5'(N_WORDS - 2)) && (r_k == 5'(N_WORDS - 1));
   // Read data lags its address by one cycle, so count c captures byte c-1.
   assign w_cap_idx   = r_cnt[5:0] - 6'd1;
   assign w_dist      = popcount16(r_ops[r_j] ^ r_ops[r_k]);
   assign done        = r_done;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      mem_addr    = '0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      case (r_state)
         S_IDLE:  if (w_trigger) w_next = S_LOAD;
         S_LOAD: begin
            if (w_load_last) w_next = S_SCAN;
            else             mem_addr = AW'(BASE_ADDR) + AW'(r_cnt);
         end
         S_SCAN:  if (w_last_pair) w_next = S_WRITE;
         S_WRITE: begin
            mem_wr_en = 1'b1;
            mem_addr  = AW'(RES_ADDR) + AW'(r_wcnt);
            case (r_wcnt)
               3'd0:    mem_wr_data = {3'b000, r_min};
               3'd1:    mem_wr_data = {3'b000, r_max};
`ifdef HAM_PAIR_ADDR_EN
               3'd2:    mem_wr_data = {3'b000, r_min_j};
               3'd3:    mem_wr_data = {3'b000, r_min_k};
               3'd4:    mem_wr_data = {3'b000, r_max_j};
               3'd5:    mem_wr_data = {3'b000, r_max_k};
`endif
               default: mem_wr_data = '0;
            endcase
            if (r_wcnt == 3'(WR_N - 1)) w_next = S_DONE;
         end
         S_DONE:  if (req) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_req_q <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
         r_wcnt  <= '0;
         r_j     <= 5'd0;
         r_k     <= 5'd1;
         r_min   <= 5'd16;
         r_max   <= 5'd0;
`ifdef HAM_PAIR_ADDR_EN
         r_min_j <= 5'd0;
         r_min_k <= 5'd1;
         r_max_j <= 5'd0;
         r_max_k <= 5'd1;
`endif
      end else begin
         r_req_q <= req;
         // Registered one cycle behind the state so done also drops one edge after req is seen.
         r_done  <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: if (w_trigger) begin
               r_cnt   <= '0;
               r_wcnt  <= '0;
               r_j     <= 5'd0;
               r_k     <= 5'd1;
               r_min   <= 5'd16;
               r_max   <= 5'd0;
`ifdef HAM_PAIR_ADDR_EN
               r_min_j <= 5'd0;
               r_min_k <= 5'd1;
               r_max_j <= 5'd0;
               r_max_k <= 5'd1;
`endif
            end
            S_LOAD: begin
               r_cnt <= r_cnt + 7'd1;
               if (r_cnt != 7'd0) begin
                  if (w_cap_idx[0]) r_ops[w_cap_idx[5:1]][7:0]  <= mem_rd_data;
                  else              r_ops[w_cap_idx[5:1]][15:8] <= mem_rd_data;
               end
            end
            S_SCAN: begin
               // Strict compares keep the earliest pair in scan order on ties.
               if (w_dist < r_min) begin
                  r_min   <= w_dist;
`ifdef HAM_PAIR_ADDR_EN
                  r_min_j <= r_j;
                  r_min_k <= r_k;
`endif
               end
               if (w_dist > r_max) begin
                  r_max   <= w_dist;
`ifdef HAM_PAIR_ADDR_EN
                  r_max_j <= r_j;
                  r_max_k <= r_k;
`endif
               end
               if (r_k == 5'(N_WORDS - 1)) begin
                  r_j <= r_j + 5'd1;
                  r_k <= r_j + 5'd2;
               end else begin
                  r_k <= r_k + 5'd1;
               end
            end
            S_WRITE: r_wcnt <= r_wcnt + 3'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ham_scan_ctrl.sv
// Directed bench for ham_scan_ctrl: byte memory model, latency/write-count checks and
// a pairwise Hamming reference for random operand files.
module tb_ham_scan_ctrl;

   localparam int N   = 32;
   localparam int RES = 64;
`ifdef HAM_PAIR_ADDR_EN
   localparam int EXP_WR  = 6;
   localparam int EXP_LAT = 568;
`else
   localparam int EXP_WR  = 2;
   localparam int EXP_LAT = 564;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req = 1'b0;
   logic       done;
   logic [7:0] mem_addr;
   logic [7:0] rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;

   logic [7:0]  mem [256];
   logic [7:0]  res_mem [8];
   logic [15:0] ops [N];
   int          wr_cnt = 0;
   int          bad_wr = 0;
   int          errors = 0;
   int          checks = 0;

   ham_scan_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .done       (done),
      .mem_addr   (mem_addr),
      .mem_rd_data(rd_data),
      .mem_wr_en  (mem_wr_en),
      .mem_wr_data(mem_wr_data)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory; results land in their own array.
   always @(posedge clk) begin
      rd_data <= mem[mem_addr];
      if (mem_wr_en) begin
         wr_cnt = wr_cnt + 1;
         if (int'(mem_addr) >= RES && int'(mem_addr) < RES + EXP_WR)
            res_mem[mem_addr - 8'(RES)] = mem_wr_data;
         else
            bad_wr = bad_wr + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic load_ops();
      for (int i = 0; i < N; i++) begin
         mem[2*i]   = ops[i][15:8];
         mem[2*i+1] = ops[i][7:0];
      end
   endtask

   task automatic start_job();
      @(negedge clk) req = 1'b1;
      @(negedge clk) req = 1'b0;
   endtask

   // lat = edges after the trigger edge T until done is seen high.
   task automatic wait_done(input bit toggle, output int lat);
      int cnt;
      cnt = 0;
      lat = -1;
      while (cnt < 3000) begin
         @(posedge clk); #1;
         cnt++;
         if (toggle) begin
            case (cnt)
               200: req = 1'b1;
               202: req = 1'b0;
               204: req = 1'b1;
               206: req = 1'b0;
               default: ;
            endcase
         end
         if (done === 1'b1) begin
            lat = cnt - 1;
            break;
         end
      end
   endtask

   task automatic release_done(input string tag);
      @(negedge clk) req = 1'b1;
      @(posedge clk); #1;
      check({tag, "_done_hold"}, done, 1);
      @(posedge clk); #1;
      check({tag, "_done_fall"}, done, 0);
   endtask

   task automatic run_job(input string tag, input int emin, input int emax,
                          input int emj, input int emk, input int exj, input int exk,
                          input bit toggle);
      int lat, w0, b0;
      load_ops();
      w0 = wr_cnt;
      b0 = bad_wr;
      start_job();
      wait_done(toggle, lat);
      check({tag, "_latency"}, lat, EXP_LAT);
      check({tag, "_writes"}, wr_cnt - w0, EXP_WR);
      check({tag, "_bad_wr"}, bad_wr - b0, 0);
      check({tag, "_min"}, res_mem[0], emin);
      check({tag, "_max"}, res_mem[1], emax);
`ifdef HAM_PAIR_ADDR_EN
      check({tag, "_min_j"}, res_mem[2], emj);
      check({tag, "_min_k"}, res_mem[3], emk);
      check({tag, "_max_j"}, res_mem[4], exj);
      check({tag, "_max_k"}, res_mem[5], exk);
`else
      if (emj + emk + exj + exk < 0) check({tag, "_idx"}, 0, 1);
`endif
      if (toggle) begin
         repeat (5) @(posedge clk);
         #1 check({tag, "_done_held_req0"}, done, 1);
      end
      release_done(tag);
   endtask

   function automatic void model(output int mn, output int mx, output int mj, output int mk,
                                 output int xj, output int xk);
      int d;
      mn = 16; mx = 0; mj = 0; mk = 1; xj = 0; xk = 1;
      for (int j = 0; j < N - 1; j++)
         for (int k = j + 1; k < N; k++) begin
            d = $countones(ops[j] ^ ops[k]);
            if (d < mn) begin mn = d; mj = j; mk = k; end
            if (d > mx) begin mx = d; xj = j; xk = k; end
         end
   endfunction

   task automatic rand_ops();
      for (int i = 0; i < N; i++) ops[i] = 16'($urandom_range(0, 65535));
   endtask

   initial begin
      int mn, mx, mj, mk, xj, xk, w0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      for (int i = 0; i < 8; i++) res_mem[i] = 8'hEE;

      repeat (3) @(posedge clk); #1;
      check("rst_done", done, 0);
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wr_data, 0);
      @(negedge clk) reset = 1'b0;
      repeat (20) @(posedge clk); #1;
      check("idle_no_wr", wr_cnt, 0);
      check("idle_done", done, 0);

      for (int i = 0; i < N; i++) ops[i] = 16'h0000;
      run_job("zero", 0, 0, 0, 1, 0, 1, 1'b0);

      ops[5] = 16'hFFFF;
      run_job("op5", 0, 16, 0, 1, 0, 5, 1'b0);

      for (int i = 0; i < N; i++) ops[i] = 16'(1 << (i % 16));
      run_job("pow2", 0, 2, 0, 16, 0, 1, 1'b0);

      // Reset in the middle of a scan aborts the job with no writes.
      rand_ops();
      load_ops();
      w0 = wr_cnt;
      start_job();
      repeat (300) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("abort_done", done, 0);
      repeat (40) @(posedge clk); #1;
      check("abort_no_wr", wr_cnt - w0, 0);
      check("abort_idle_addr", mem_addr, 0);
      check("abort_idle_done", done, 0);
      rand_ops();
      model(mn, mx, mj, mk, xj, xk);
      run_job("after_abort", mn, mx, mj, mk, xj, xk, 1'b0);

      // req toggles during SCAN must not restart the job.
      rand_ops();
      model(mn, mx, mj, mk, xj, xk);
      run_job("toggle", mn, mx, mj, mk, xj, xk, 1'b1);
      ops[7] = ~ops[3];
      model(mn, mx, mj, mk, xj, xk);
      run_job("after_toggle", mn, mx, mj, mk, xj, xk, 1'b0);

      for (int r = 0; r < 10; r++) begin
         rand_ops();
         model(mn, mx, mj, mk, xj, xk);
         run_job($sformatf("rand%0d", r), mn, mx, mj, mk, xj, xk, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
